sdram_port_scheduler: RTL and testbench
=======================================

Name: sdram_port_scheduler

Overview:
- Parametrised burst scheduler for the SDRAM frame-buffer controller, serving N_WR write FIFOs and N_RD read FIFOs.
- Watches FIFO fill levels and selects one port per burst.
- Keeps a wrapping address pointer for each port.
- Issues one burst command (address, length, direction) to the SDRAM command engine.
- Adds round-robin fairness within each class and a selectable read/write priority mode, so it scales past two ports per direction.

Parameters:
N_WR, 2, number of write ports (1..8)
N_RD, 2, number of read ports (1..8)
ASIZE, 23, word address width
LSIZE, 9, burst length width
USEDW, 16, FIFO level width
RD_PRIORITY, 1, 1 = any eligible read beats any write; 0 = strict alternation between classes when both are eligible

Ports:
CLK  in  1  single system clock
RESET  in  1  asynchronous, active-high reset
WR_ADDR  in  N_WR*ASIZE  per-port start address, port i at [i*ASIZE +: ASIZE]
WR_MAX_ADDR  in  N_WR*ASIZE  per-port wrap limit
WR_LENGTH  in  N_WR*LSIZE  per-port burst length
WR_LOAD  in  N_WR  per-port pointer reload (level)
WR_LEVEL  in  N_WR*USEDW  write-FIFO read-side used words
RD_ADDR, RD_MAX_ADDR, RD_LENGTH, RD_LOAD  in  as WR_*, N_RD ports  read-side equivalents
RD_LEVEL  in  N_RD*USEDW  read-FIFO write-side used words
CMD_REQ  out  1  burst request to command engine
CMD_WRITE  out  1  1 = write burst, 0 = read burst
CMD_ADDR  out  ASIZE  burst start address
CMD_LENGTH  out  LSIZE  burst length
CMD_ACK  in  1  command accepted (1-cycle pulse)
CMD_DONE  in  1  burst complete (1-cycle pulse)
WR_MASK  out  N_WR  one-hot granted write port; steers FIFO rdreq
RD_MASK  out  N_RD  one-hot granted read port; steers FIFO wrreq
BUSY  out  1  high whenever state != IDLE

Behaviour:
Reset:
- Async assert clears all outputs, state = IDLE, round-robin pointers = 0, class toggle = read-first.
- Clears per-port valid bits and pointers to 0.

Pointer init:
- The first CLK edge after reset deassertion loads every pointer from its start address and sets valid.
- A port with valid = 0 is never eligible.

Eligibility, registered inputs not needed:
- Read port i: valid, RD_LENGTH != 0, RD_LEVEL < RD_LENGTH.
- Write port j: valid, WR_LENGTH != 0, WR_LEVEL >= WR_LENGTH.
- Any asserted *_LOAD bit blocks new grants.

State machine IDLE / REQ / BURST:
- IDLE, if something is eligible: pick a class and a port; register CMD_ADDR = pointer, CMD_LENGTH, CMD_WRITE, and a one-hot mask; set CMD_REQ = 1; go to REQ. This takes 1 cycle from eligibility to CMD_REQ.
- REQ: hold CMD_REQ and all CMD_* stable until CMD_ACK; then CMD_REQ = 0 and go to BURST. CMD_ACK is ignored outside REQ. CMD_DONE in REQ is ignored.
- BURST: on CMD_DONE, clear both masks, update the granted pointer, go to IDLE. The earliest next CMD_REQ is 2 cycles after CMD_DONE.

Class selection:
- RD_PRIORITY = 1: reads first.
- RD_PRIORITY = 0: when both classes are eligible, serve the class not served last. A single eligible class is always served.

Round-robin within a class:
- Search starts at last-granted index + 1, modulo N.
- After a grant, the pointer is set to the granted index.

Pointer update on DONE (arithmetic in ASIZE+1 bits):
- If ptr + len < max: ptr = ptr + len.
- Otherwise ptr = start address (this includes max < len).

LOAD:
- LOAD of a port reloads its pointer every cycle it is high. LOAD wins over the DONE update the same cycle.
- LOAD during a granted burst does not abort it. The burst completes and the pointer stays at the loaded start.

Masks stay asserted from grant until the cycle after CMD_DONE. Exactly one mask bit is set during a burst; none are set in IDLE.

Test Plan:
- Reset release, N_RD=2, RD_LEVEL = {0,0}, RD_LENGTH = 256, RD_ADDR = {0x100000, 0}:
  - CMD_REQ rises, RD_MASK = 01, CMD_ADDR = 0, CMD_WRITE = 0.
  - After ACK + DONE, port 1 is granted next with CMD_ADDR = 0x100000.
- Wrap, start 0, max 640, len 256:
  - Successive CMD_DONE give pointers 256, 512, then 0 (512 + 256 >= 640).
  - max = 100 with len = 256 stays at 0.
- RD_PRIORITY = 0, with both write ports and read port 0 continuously eligible:
  - Grant order: R0, W0, R0, W1, R0, W0.
- WR_LOAD pulsed while the write port 0 burst is in BURST: burst completes, and the next grant of W0 uses WR_ADDR.
  - With WR_LOAD held, no CMD_REQ is issued.
- CMD_REQ held 5 cycles without ACK: CMD_ADDR, CMD_LENGTH and CMD_WRITE stay stable.
  - A DONE pulse in REQ does not change state.
  - RESET asserted in BURST clears CMD_REQ, masks and BUSY asynchronously.

Source files
------------

// File: rtl/sdram_port_scheduler_if.sv
// Command handshake between the burst scheduler and the SDRAM command engine,
// plus the one-hot port masks that steer FIFO rdreq/wrreq during a burst.
// master = scheduler side, slave = command engine / FIFO steering side.
interface sdram_port_scheduler_if #(
    parameter int N_WR  = 2,
    parameter int N_RD  = 2,
    parameter int ASIZE = 23,
    parameter int LSIZE = 9
);
    logic             cmd_req;
    logic             cmd_write;
    logic [ASIZE-1:0] cmd_addr;
    logic [LSIZE-1:0] cmd_length;
    logic             cmd_ack;
    logic             cmd_done;
    logic [N_WR-1:0]  wr_mask;
    logic [N_RD-1:0]  rd_mask;
    logic             busy;

    modport master (
        output cmd_req, cmd_write, cmd_addr, cmd_length, wr_mask, rd_mask, busy,
        input  cmd_ack, cmd_done
    );

    modport slave (
        input  cmd_req, cmd_write, cmd_addr, cmd_length, wr_mask, rd_mask, busy,
        output cmd_ack, cmd_done
    );
endinterface

// File: rtl/sdram_port_scheduler.sv
// Picks one read/write FIFO port per SDRAM burst, keeps per-port wrapping pointers.
// Latency: 1 cycle from eligibility to cmd_req; next cmd_req earliest 2 cycles after cmd_done.
// Backpressure: cmd_* held stable in REQ until cmd_ack; any load bit blocks new grants.
module sdram_port_scheduler #(
    parameter int N_WR        = 2,
    parameter int N_RD        = 2,
    parameter int ASIZE       = 23,
    parameter int LSIZE       = 9,
    parameter int USEDW       = 16,
    parameter int RD_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_WR*ASIZE-1:0]   wr_addr,
    input  logic [N_WR*ASIZE-1:0]   wr_max_addr,
    input  logic [N_WR*LSIZE-1:0]   wr_length,
    input  logic [N_WR-1:0]         wr_load,
    input  logic [N_WR*USEDW-1:0]   wr_level,
    input  logic [N_RD*ASIZE-1:0]   rd_addr,
    input  logic [N_RD*ASIZE-1:0]   rd_max_addr,
    input  logic [N_RD*LSIZE-1:0]   rd_length,
    input  logic [N_RD-1:0]         rd_load,
    input  logic [N_RD*USEDW-1:0]   rd_level,
    sdram_port_scheduler_if.master  cmd
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    logic [1:0]       state;
    logic [ASIZE-1:0] wr_ptr [N_WR];
    logic [ASIZE-1:0] rd_ptr [N_RD];
    logic [N_WR-1:0]  wr_valid;
    logic [N_RD-1:0]  rd_valid;
    // Last granted index per class; the *_seen bit makes the very first search start at port 0.
    logic [2:0]       wr_rr;
    logic [2:0]       rd_rr;
    logic             wr_seen;
    logic             rd_seen;
    // 1 = the most recent grant went to the read class.
    logic             last_rd;
    // Granted port was reloaded during this burst, so its pointer must not advance on done.
    logic             reload_hit;

    logic [N_WR-1:0]  wr_elig;
    logic [N_RD-1:0]  rd_elig;
    logic [N_WR-1:0]  wr_pick;
    logic [N_RD-1:0]  rd_pick;
    logic [2:0]       wr_pick_idx;
    logic [2:0]       rd_pick_idx;
    logic             wr_found;
    logic             rd_found;
    logic             grant_rd;
    logic             grant_wr;
    logic             do_grant;
    logic             any_load;
    logic [ASIZE-1:0] sel_addr;
    logic [LSIZE-1:0] sel_len;

    // Round-robin search origin: one past the last grant, or port 0 before any grant.
    function automatic logic [3:0] rr_base(input logic seen, input logic [2:0] last, input int n);
        if (!seen || int'(last) >= n - 1)
            return 4'd0;
        return 4'(last) + 4'd1;
    endfunction

    // k-th slot of the circular search starting at base.
    function automatic logic [3:0] rr_slot(input logic [3:0] base, input int k, input int n);
        logic [3:0] s;
        s = base + 4'(k);
        if (s >= 4'(n))
            s = s - 4'(n);
        return s;
    endfunction

    // Advance by one burst; wrap to the start address when the end would reach the limit.
    function automatic logic [ASIZE-1:0] advance(input logic [ASIZE-1:0] ptr,
                                                 input logic [ASIZE-1:0] start,
                                                 input logic [ASIZE-1:0] lim,
                                                 input logic [LSIZE-1:0] len);
        logic [ASIZE:0] sum;
        sum = {1'b0, ptr} + (ASIZE+1)'(len);
        if (sum < {1'b0, lim})
            return sum[ASIZE-1:0];
        return start;
    endfunction

    // Port eligibility straight from the live FIFO levels.
    always_comb begin
        wr_elig = '0;
        rd_elig = '0;
        for (int i = 0; i < N_WR; i++)
            wr_elig[i] = wr_valid[i] && (wr_length[i*LSIZE +: LSIZE] != '0) &&
                         (32'(wr_level[i*USEDW +: USEDW]) >= 32'(wr_length[i*LSIZE +: LSIZE]));
        for (int i = 0; i < N_RD; i++)
            rd_elig[i] = rd_valid[i] && (rd_length[i*LSIZE +: LSIZE] != '0) &&
                         (32'(rd_level[i*USEDW +: USEDW]) < 32'(rd_length[i*LSIZE +: LSIZE]));
    end

    // Round-robin pick of the first eligible write port after the last grant.
    always_comb begin
        wr_found    = 1'b0;
        wr_pick_idx = '0;
        wr_pick     = '0;
        for (int k = 0; k < N_WR; k++)
            for (int i = 0; i < N_WR; i++)
                if (!wr_found && wr_elig[i] && rr_slot(rr_base(wr_seen, wr_rr, N_WR), k, N_WR) == 4'(i)) begin
                    wr_found    = 1'b1;
                    wr_pick_idx = 3'(i);
                end
        for (int i = 0; i < N_WR; i++)
            wr_pick[i] = wr_found && (wr_pick_idx == 3'(i));
    end

    // Round-robin pick of the first eligible read port after the last grant.
    always_comb begin
        rd_found    = 1'b0;
        rd_pick_idx = '0;
        rd_pick     = '0;
        for (int k = 0; k < N_RD; k++)
            for (int i = 0; i < N_RD; i++)
                if (!rd_found && rd_elig[i] && rr_slot(rr_base(rd_seen, rd_rr, N_RD), k, N_RD) == 4'(i)) begin
                    rd_found    = 1'b1;
                    rd_pick_idx = 3'(i);
                end
        for (int i = 0; i < N_RD; i++)
            rd_pick[i] = rd_found && (rd_pick_idx == 3'(i));
    end

    // Class choice and the address/length of the winning port.
    always_comb begin
        any_load = (|wr_load) || (|rd_load);
        grant_rd = rd_found && ((RD_PRIORITY != 0) || !wr_found || !last_rd);
        grant_wr = wr_found && !grant_rd;
        do_grant = (state == IDLE) && !any_load && (rd_found || wr_found);
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < N_WR; i++)
            if (grant_wr && wr_pick[i]) begin
                sel_addr = wr_ptr[i];
                sel_len  = wr_length[i*LSIZE +: LSIZE];
            end
        for (int i = 0; i < N_RD; i++)
            if (grant_rd && rd_pick[i]) begin
                sel_addr = rd_ptr[i];
                sel_len  = rd_length[i*LSIZE +: LSIZE];
            end
    end

    assign cmd.busy = (state != IDLE);

    // Write pointers: initial load, level-sensitive reload, advance on burst completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid <= '0;
            for (int i = 0; i < N_WR; i++)
                wr_ptr[i] <= '0;
        end else begin
            for (int i = 0; i < N_WR; i++) begin
                if (!wr_valid[i] || wr_load[i]) begin
                    wr_ptr[i]   <= wr_addr[i*ASIZE +: ASIZE];
                    wr_valid[i] <= 1'b1;
                end else if (state == BURST && cmd.cmd_done && cmd.wr_mask[i] && !reload_hit) begin
                    wr_ptr[i] <= advance(wr_ptr[i], wr_addr[i*ASIZE +: ASIZE],
                                         wr_max_addr[i*ASIZE +: ASIZE], wr_length[i*LSIZE +: LSIZE]);
                end
            end
        end
    end

    // Read pointers: initial load, level-sensitive reload, advance on burst completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
            for (int i = 0; i < N_RD; i++)
                rd_ptr[i] <= '0;
        end else begin
            for (int i = 0; i < N_RD; i++) begin
                if (!rd_valid[i] || rd_load[i]) begin
                    rd_ptr[i]   <= rd_addr[i*ASIZE +: ASIZE];
                    rd_valid[i] <= 1'b1;
                end else if (state == BURST && cmd.cmd_done && cmd.rd_mask[i] && !reload_hit) begin
                    rd_ptr[i] <= advance(rd_ptr[i], rd_addr[i*ASIZE +: ASIZE],
                                         rd_max_addr[i*ASIZE +: ASIZE], rd_length[i*LSIZE +: LSIZE]);
                end
            end
        end
    end

    // Grant / request / burst sequencing and the registered command outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cmd.cmd_req    <= 1'b0;
            cmd.cmd_write  <= 1'b0;
            cmd.cmd_addr   <= '0;
            cmd.cmd_length <= '0;
            cmd.wr_mask    <= '0;
            cmd.rd_mask    <= '0;
            wr_rr          <= '0;
            rd_rr          <= '0;
            wr_seen        <= 1'b0;
            rd_seen        <= 1'b0;
            last_rd        <= 1'b0;
            reload_hit     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        cmd.cmd_req    <= 1'b1;
                        cmd.cmd_write  <= grant_wr;
                        cmd.cmd_addr   <= sel_addr;
                        cmd.cmd_length <= sel_len;
                        cmd.wr_mask    <= grant_wr ? wr_pick : '0;
                        cmd.rd_mask    <= grant_rd ? rd_pick : '0;
                        last_rd        <= grant_rd;
                        reload_hit     <= 1'b0;
                        if (grant_rd) begin
                            rd_rr   <= rd_pick_idx;
                            rd_seen <= 1'b1;
                        end else begin
                            wr_rr   <= wr_pick_idx;
                            wr_seen <= 1'b1;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if ((|(wr_load & cmd.wr_mask)) || (|(rd_load & cmd.rd_mask)))
                        reload_hit <= 1'b1;
                    if (cmd.cmd_ack) begin
                        cmd.cmd_req <= 1'b0;
                        state       <= BURST;
                    end
                end
                BURST: begin
                    if ((|(wr_load & cmd.wr_mask)) || (|(rd_load & cmd.rd_mask)))
                        reload_hit <= 1'b1;
                    if (cmd.cmd_done) begin
                        cmd.wr_mask <= '0;
                        cmd.rd_mask <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench: dut alternates classes (RD_PRIORITY=0), dut_rp gives reads priority.
// Expected grants, addresses and masks are hand-computed per step.
// Every wait on the DUT is bounded.
module tb_sdram_port_scheduler;
    localparam int N_WR  = 2;
    localparam int N_RD  = 2;
    localparam int ASIZE = 23;
    localparam int LSIZE = 9;
    localparam int USEDW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    logic [N_WR*ASIZE-1:0] wr_addr, wr_max_addr;
    logic [N_WR*LSIZE-1:0] wr_length;
    logic [N_WR-1:0]       wr_load;
    logic [N_WR*USEDW-1:0] wr_level;
    logic [N_RD*ASIZE-1:0] rd_addr, rd_max_addr;
    logic [N_RD*LSIZE-1:0] rd_length;
    logic [N_RD-1:0]       rd_load;
    logic [N_RD*USEDW-1:0] rd_level;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sdram_port_scheduler_if #(.N_WR(N_WR), .N_RD(N_RD), .ASIZE(ASIZE), .LSIZE(LSIZE)) ifa ();
    sdram_port_scheduler_if #(.N_WR(N_WR), .N_RD(N_RD), .ASIZE(ASIZE), .LSIZE(LSIZE)) ifb ();

    sdram_port_scheduler #(.N_WR(N_WR), .N_RD(N_RD), .ASIZE(ASIZE), .LSIZE(LSIZE),
                           .USEDW(USEDW), .RD_PRIORITY(0)) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .wr_length(wr_length),
        .wr_load(wr_load), .wr_level(wr_level),
        .rd_addr(rd_addr), .rd_max_addr(rd_max_addr), .rd_length(rd_length),
        .rd_load(rd_load), .rd_level(rd_level),
        .cmd(ifa)
    );

    sdram_port_scheduler #(.N_WR(N_WR), .N_RD(N_RD), .ASIZE(ASIZE), .LSIZE(LSIZE),
                           .USEDW(USEDW), .RD_PRIORITY(1)) dut_rp (
        .clk(clk), .rst(rst_b),
        .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .wr_length(wr_length),
        .wr_load(wr_load), .wr_level(wr_level),
        .rd_addr(rd_addr), .rd_max_addr(rd_max_addr), .rd_length(rd_length),
        .rd_load(rd_load), .rd_level(rd_level),
        .cmd(ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic req_of(input int sel);
        return (sel != 0) ? ifb.cmd_req : ifa.cmd_req;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel != 0) ? ifb.busy : ifa.busy;
    endfunction
    function automatic logic write_of(input int sel);
        return (sel != 0) ? ifb.cmd_write : ifa.cmd_write;
    endfunction
    function automatic logic [ASIZE-1:0] addr_of(input int sel);
        return (sel != 0) ? ifb.cmd_addr : ifa.cmd_addr;
    endfunction
    function automatic logic [LSIZE-1:0] len_of(input int sel);
        return (sel != 0) ? ifb.cmd_length : ifa.cmd_length;
    endfunction
    // {wr_mask, rd_mask}
    function automatic logic [3:0] masks_of(input int sel);
        return (sel != 0) ? {ifb.wr_mask, ifb.rd_mask} : {ifa.wr_mask, ifa.rd_mask};
    endfunction

    task automatic set_ack(input int sel, input logic v);
        if (sel != 0) ifb.cmd_ack = v; else ifa.cmd_ack = v;
    endtask
    task automatic set_done(input int sel, input logic v);
        if (sel != 0) ifb.cmd_done = v; else ifa.cmd_done = v;
    endtask

    task automatic wait_req(input int sel, input string tag);
        int n = 0;
        while (req_of(sel) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req"}, 32'(req_of(sel)), 32'd1);
    endtask

    task automatic expect_grant(input int sel, input string tag, input logic wr,
                                input logic [3:0] masks, input logic [ASIZE-1:0] addr);
        wait_req(sel, tag);
        check({tag, " addr"},  32'(addr_of(sel)),  32'(addr));
        check({tag, " write"}, 32'(write_of(sel)), 32'(wr));
        check({tag, " masks"}, 32'(masks_of(sel)), 32'(masks));
        check({tag, " len"},   32'(len_of(sel)),   32'd256);
    endtask

    // Acknowledge, then complete the burst; returns at the negedge after the done edge.
    task automatic serve(input int sel, input string tag);
        set_ack(sel, 1'b1);
        @(negedge clk);
        set_ack(sel, 1'b0);
        check({tag, " req drop"}, 32'(req_of(sel)), 32'd0);
        check({tag, " busy burst"}, 32'(busy_of(sel)), 32'd1);
        set_done(sel, 1'b1);
        @(negedge clk);
        set_done(sel, 1'b0);
        check({tag, " busy idle"}, 32'(busy_of(sel)), 32'd0);
        check({tag, " masks idle"}, 32'(masks_of(sel)), 32'd0);
    endtask

    initial begin
        ifa.cmd_ack = 1'b0; ifa.cmd_done = 1'b0;
        ifb.cmd_ack = 1'b0; ifb.cmd_done = 1'b0;
        wr_addr     = {23'h300000, 23'h200000};
        wr_max_addr = {23'h7FFFFF, 23'h7FFFFF};
        wr_length   = {9'd256, 9'd256};
        wr_load     = '0;
        wr_level    = {16'd0, 16'd0};
        rd_addr     = {23'h100000, 23'h000000};
        rd_max_addr = {23'h7FFFFF, 23'h7FFFFF};
        rd_length   = {9'd256, 9'd256};
        rd_load     = '0;
        rd_level    = {16'd0, 16'd0};

        repeat (2) @(negedge clk);
        check("reset req",   32'(ifa.cmd_req), 32'd0);
        check("reset busy",  32'(ifa.busy), 32'd0);
        check("reset masks", 32'(masks_of(0)), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("init cycle req", 32'(ifa.cmd_req), 32'd0);
        @(negedge clk);
        check("first req latency", 32'(ifa.cmd_req), 32'd1);
        expect_grant(0, "r0 first", 1'b0, 4'b0001, 23'h000000);

        // No ack for 5 cycles: command must hold.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold req",   32'(ifa.cmd_req), 32'd1);
            check("hold addr",  32'(ifa.cmd_addr), 32'd0);
            check("hold len",   32'(ifa.cmd_length), 32'd256);
            check("hold write", 32'(ifa.cmd_write), 32'd0);
        end
        ifa.cmd_done = 1'b1;
        @(negedge clk);
        ifa.cmd_done = 1'b0;
        check("done in req keeps req",  32'(ifa.cmd_req), 32'd1);
        check("done in req keeps mask", 32'(masks_of(0)), 32'b0001);
        serve(0, "r0 first");

        expect_grant(0, "r1 rr", 1'b0, 4'b0010, 23'h100000);
        serve(0, "r1 rr");

        // Wrap: start 0, max 640, len 256; port 1 made ineligible.
        rd_max_addr[0 +: ASIZE] = 23'd640;
        rd_level[USEDW +: USEDW] = 16'd256;
        expect_grant(0, "wrap 256", 1'b0, 4'b0001, 23'd256);
        serve(0, "wrap 256");
        expect_grant(0, "wrap 512", 1'b0, 4'b0001, 23'd512);
        serve(0, "wrap 512");
        expect_grant(0, "wrap 0", 1'b0, 4'b0001, 23'd0);
        rd_max_addr[0 +: ASIZE] = 23'd100;
        serve(0, "wrap 0");
        expect_grant(0, "max<len a", 1'b0, 4'b0001, 23'd0);
        serve(0, "max<len a");
        expect_grant(0, "max<len b", 1'b0, 4'b0001, 23'd0);

        // Async reset in BURST.
        ifa.cmd_ack = 1'b1;
        @(negedge clk);
        ifa.cmd_ack = 1'b0;
        check("pre-reset mask", 32'(masks_of(0)), 32'b0001);
        #2 rst = 1'b1;
        #1;
        check("async rst req",   32'(ifa.cmd_req), 32'd0);
        check("async rst masks", 32'(masks_of(0)), 32'd0);
        check("async rst busy",  32'(ifa.busy), 32'd0);

        // Alternation: R0, W0, W1 eligible; R1 not.
        rd_max_addr[0 +: ASIZE] = 23'h7FFFFF;
        wr_level = {16'd256, 16'd256};
        @(negedge clk);
        rst = 1'b0;
        expect_grant(0, "alt1 r0", 1'b0, 4'b0001, 23'h000000);
        serve(0, "alt1");
        expect_grant(0, "alt2 w0", 1'b1, 4'b0100, 23'h200000);
        serve(0, "alt2");
        expect_grant(0, "alt3 r0", 1'b0, 4'b0001, 23'h000100);
        serve(0, "alt3");
        expect_grant(0, "alt4 w1", 1'b1, 4'b1000, 23'h300000);
        serve(0, "alt4");
        expect_grant(0, "alt5 r0", 1'b0, 4'b0001, 23'h000200);
        serve(0, "alt5");
        expect_grant(0, "alt6 w0", 1'b1, 4'b0100, 23'h200100);

        // Only W0 eligible from here; LOAD pulsed mid-burst.
        rd_level[0 +: USEDW] = 16'd256;
        wr_level[USEDW +: USEDW] = 16'd0;
        ifa.cmd_ack = 1'b1;
        @(negedge clk);
        ifa.cmd_ack = 1'b0;
        wr_addr[0 +: ASIZE] = 23'h250000;
        wr_load[0] = 1'b1;
        @(negedge clk);
        wr_load[0] = 1'b0;
        check("load keeps burst mask", 32'(masks_of(0)), 32'b0100);
        check("load keeps busy", 32'(ifa.busy), 32'd1);
        ifa.cmd_done = 1'b1;
        @(negedge clk);
        ifa.cmd_done = 1'b0;
        check("load burst ends", 32'(ifa.busy), 32'd0);
        expect_grant(0, "w0 reloaded", 1'b1, 4'b0100, 23'h250000);
        serve(0, "w0 reloaded");

        // Held LOAD blocks every grant.
        wr_load[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("load held no req", 32'(ifa.cmd_req), 32'd0);
        end
        wr_load[0] = 1'b0;
        expect_grant(0, "w0 after held load", 1'b1, 4'b0100, 23'h250000);

        // Read-priority instance: reads beat eligible writes.
        rd_level = {16'd0, 16'd0};
        wr_level = {16'd256, 16'd256};
        rst_b = 1'b0;
        expect_grant(1, "prio r0", 1'b0, 4'b0001, 23'h000000);
        serve(1, "prio r0");
        expect_grant(1, "prio r1", 1'b0, 4'b0010, 23'h100000);
        serve(1, "prio r1");
        expect_grant(1, "prio r0 again", 1'b0, 4'b0001, 23'h000100);
        serve(1, "prio r0 again");
        rd_level = {16'd256, 16'd256};
        expect_grant(1, "prio w0", 1'b1, 4'b0100, 23'h250000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
